bk_memarb: RTL and testbench
============================

# bk_memarb

Two-port memory arbiter sharing the single 16-bit external RAM port between the CPU bus and the VGA scanline fetcher. Sits between the `bk0010` core and the SDRAM/SRAM controller, replacing the direct `vga_addr`/`vdata`/`membusy` wiring. Video has priority, bounded by a fairness counter so the CPU is never starved. Requests are sequenced one at a time through a four-state FSM.

## Interface
- `VID_BASE`, 18'h02000: word address of screen RAM; added to the video word offset.
- `MAX_VID_BURST`, 4: consecutive video grants allowed while a CPU request waits; range 1..15.
- `TIMEOUT`, 255: watchdog limit in cycles; used only with `ARB_TIMEOUT_EN`.
- `clk25`  in  1  system clock.
- `reset_in`  in  1  synchronous, active-high reset.
- `vid_req`  in  1  video read request, level, held until `vid_ack`.
- `vid_addr`  in  13  video word offset.
- `vid_data`  out  16  video read data, valid with `vid_ack`, held after.
- `vid_ack`  out  1  one-cycle completion pulse.
- `cpu_req`  in  1  CPU request, level, held until `cpu_ack`.
- `cpu_we`  in  1  1 = write.
- `cpu_addr`  in  18  CPU word address.
- `cpu_be`  in  2  byte enables {UB, LB}, active-high.
- `cpu_wdata`  in  16  write data.
- `cpu_rdata`  out  16  read data, valid with `cpu_ack`, held after.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  request to memory controller.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  18  word address.
- `mem_be`  out  2  byte enables.
- `mem_wdata`  out  16  write data.
- `mem_busy`  in  1  controller cannot accept (`membusy`).
- `mem_ack`  in  1  one-cycle transfer-complete pulse.
- `mem_rdata`  in  16  read data, valid with `mem_ack`.
- `arb_err`  out  1  sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: no request -> stay. One request -> grant it. Both pending -> video wins unless `vid_cnt == MAX_VID_BURST`, then CPU wins. Grant latches `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` and the owner, then moves to ISSUE.
- Video transfers: `mem_addr = VID_BASE + vid_addr`, computed mod 2^18 (wraps); `mem_we = 0`; `mem_be = 2'b11`.
- CPU transfers: the CPU fields pass through unchanged.
- ISSUE: `mem_req = 1`. Accepted when `!mem_busy` -> WAIT. Otherwise hold with all fields stable.
- WAIT: on `mem_ack`, latch `mem_rdata` into the owner's data register (CPU writes leave `cpu_rdata` unchanged) -> DONE.
- DONE: owner's ack = 1 for exactly one cycle. Requests are not sampled in DONE. Next state is IDLE.
- `vid_cnt` (4-bit):
  - increments on a video grant while `cpu_req` = 1, saturating at `MAX_VID_BURST`;
  - clears on a CPU grant;
  - clears on a video grant while `cpu_req` = 0.
- A `mem_ack` arriving in IDLE, ISSUE or DONE is ignored.
- Reset values: state IDLE; `mem_req`, `mem_we`, `vid_ack`, `cpu_ack`, `arb_err` = 0; `mem_addr`, `mem_wdata`, `vid_data`, `cpu_rdata` = 0; `mem_be` = 0; `vid_cnt` = 0.
- Reset mid-transfer: abort immediately, no ack is issued, and a later stray `mem_ack` is ignored.

## Timing
- All outputs are registered.
- Minimum latency: request seen in IDLE at cycle 0; `mem_req` at cycle 1; `mem_ack` at cycle 2 at the earliest; ack pulse at cycle 3.
- Each `mem_busy` cycle in ISSUE adds one cycle. Each cycle without `mem_ack` in WAIT adds one cycle.
- Requester rule: drop `req` on the edge after sampling ack. A `req` still high in the following IDLE cycle is a new request.
- Back-to-back throughput: one transfer per 4 cycles minimum.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - an 8-bit counter runs during ISSUE+WAIT and clears on entry to ISSUE;
  - when it reaches `TIMEOUT` -> DONE, owner data = 16'hFFFF, `arb_err` set (sticky until reset), `mem_req` dropped.
- Undefined: no counter; the FSM waits forever; `arb_err` is tied 0.

## Structure
- Package `bk_memarb_pkg`:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - owner encoding (VID=0, CPU=1);
  - default `VID_BASE`;
  - the timeout-fill constant 16'hFFFF.
- Sub-module `bk_memarb_fair`: holds `vid_cnt` and the tie-break decision. Inputs: both requests, grant strobe, owner. Output: `cpu_wins`.
- Everything else stays in `bk_memarb`.

## Test plan
- CPU-only read, `cpu_addr`=18'h00100, `mem_busy`=0, `mem_ack` one cycle after accept with `mem_rdata`=16'hA5A5 -> `mem_req` at cycle 1, `cpu_ack` at cycle 3, `cpu_rdata`=16'hA5A5.
- Video read, `vid_addr`=13'h1FFF -> `mem_addr`=18'h03FFF, `mem_be`=2'b11, `mem_we`=0. Repeat with `VID_BASE`=18'h3FFFF and `vid_addr`=2 -> `mem_addr`=18'h00001 (wrap).
- Both held continuously, `MAX_VID_BURST`=4 -> grant order V,V,V,V,C,V,V,V,V,C.
- CPU write, `cpu_be`=2'b01, `mem_busy` high 5 cycles -> all `mem_*` fields stable during the stall, `cpu_ack` 5 cycles later than nominal, `cpu_rdata` unchanged.
- Reset asserted in WAIT, then `mem_ack` arrives while in IDLE -> no ack pulse, outputs at reset values.
- With `ARB_TIMEOUT_EN`, `TIMEOUT`=16, `mem_ack` never arrives -> ack after timeout with data 16'hFFFF, `arb_err`=1, and the next transfer completes normally.

Source files
------------

// File: rtl/bk_memarb_pkg.sv
// rtl/bk_memarb_pkg.sv - shared types and constants for the bk_memarb memory arbiter
// Purpose: FSM state encoding, transfer owner encoding, default screen base
//          address, timeout fill pattern and the video address helper.
// Ports:   none (package).
package bk_memarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  localparam logic [17:0] DEF_VID_BASE = 18'h02000;
  localparam logic [15:0] TIMEOUT_FILL = 16'hFFFF;

  // Screen word offset relocated to the RAM word space; wraps mod 2^18.
  function automatic logic [17:0] vid_word_addr(input logic [17:0] base,
                                                input logic [12:0] offset);
    return base + {5'd0, offset};
  endfunction

endpackage

// File: rtl/bk_memarb_fair.sv
// rtl/bk_memarb_fair.sv - video-burst fairness counter and CPU/video tie-break
// Purpose: counts consecutive video grants taken while the CPU waits and forces
//          a CPU grant once MAX_VID_BURST of them have been issued.
// Ports:   clk25      system clock
//          reset_in   synchronous active-high reset
//          vid_req    video request level
//          cpu_req    CPU request level
//          grant      one-cycle strobe: a transfer is granted this cycle
//          owner      owner being granted this cycle
//          cpu_wins   CPU gets the next grant
module bk_memarb_fair
  import bk_memarb_pkg::*;
#(
  parameter int MAX_VID_BURST = 4
) (
  input  logic   clk25,
  input  logic   reset_in,
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   grant,
  input  owner_e owner,
  output logic   cpu_wins
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_VID_BURST);

  logic [3:0] vid_cnt_q, vid_cnt_d;

  always_comb begin
    vid_cnt_d = vid_cnt_q;
    if (grant) begin
      if (owner == OWN_CPU) begin
        vid_cnt_d = 4'd0;
      end else if (cpu_req) begin
        // Video overtook a waiting CPU request: count it, saturating.
        vid_cnt_d = (vid_cnt_q >= MAX_CNT) ? MAX_CNT : vid_cnt_q + 4'd1;
      end else begin
        vid_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (reset_in) begin
      vid_cnt_q <= 4'd0;
    end else begin
      vid_cnt_q <= vid_cnt_d;
    end
  end

  assign cpu_wins = cpu_req && (!vid_req || (vid_cnt_q >= MAX_CNT));

endmodule

// File: rtl/bk_memarb.sv
// rtl/bk_memarb.sv - two-port (CPU/video) arbiter for the shared 16-bit RAM port
// Purpose: sequences one transfer at a time through IDLE/ISSUE/WAIT/DONE, video
//          first but bounded by bk_memarb_fair so the CPU is never starved.
//          Optional watchdog enabled by defining ARB_TIMEOUT_EN.
// Ports:   clk25, reset_in                       clock, sync active-high reset
//          vid_req, vid_addr -> vid_data, vid_ack video read port
//          cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata -> cpu_rdata, cpu_ack
//          mem_req, mem_we, mem_addr, mem_be, mem_wdata -> memory controller
//          mem_busy, mem_ack, mem_rdata           <- memory controller
//          arb_err                                sticky watchdog flag
module bk_memarb
  import bk_memarb_pkg::*;
#(
  parameter logic [17:0] VID_BASE      = DEF_VID_BASE,
  parameter int          MAX_VID_BURST = 4,
  parameter int          TIMEOUT       = 255
) (
  input  logic        clk25,
  input  logic        reset_in,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [17:0] cpu_addr,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [17:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic        mem_busy,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        arb_err
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [17:0] mem_addr_q, mem_addr_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] vid_data_q, vid_data_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic        vid_ack_q, vid_ack_d;
  logic        cpu_ack_q, cpu_ack_d;

  logic        grant;
  logic        cpu_wins;
  owner_e      grant_owner;
  logic        to_fire;
  logic        ack_done;

  // Requests are only sampled in IDLE, so DONE never re-grants the same level.
  assign grant       = (state_q == ST_IDLE) && (vid_req || cpu_req);
  assign grant_owner = cpu_wins ? OWN_CPU : OWN_VID;
  assign ack_done    = (state_q == ST_WAIT) && mem_ack;

  bk_memarb_fair #(
    .MAX_VID_BURST(MAX_VID_BURST)
  ) u_fair (
    .clk25   (clk25),
    .reset_in(reset_in),
    .vid_req (vid_req),
    .cpu_req (cpu_req),
    .grant   (grant),
    .owner   (grant_owner),
    .cpu_wins(cpu_wins)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  logic [7:0] to_cnt_q, to_cnt_d;
  logic       arb_err_q, arb_err_d;
  logic       in_xfer;

  assign in_xfer = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  // A real ack in the same cycle as the limit wins over the watchdog.
  assign to_fire = in_xfer && (to_cnt_q == TO_LIMIT) && !ack_done;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (grant) begin
      to_cnt_d = 8'd0;
    end else if (in_xfer) begin
      to_cnt_d = to_cnt_q + 8'd1;
    end
    arb_err_d = arb_err_q | to_fire;
  end

  always_ff @(posedge clk25) begin
    if (reset_in) begin
      to_cnt_q  <= 8'd0;
      arb_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign arb_err = arb_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign to_fire        = 1'b0;
  assign arb_err        = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk25) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_VID;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 18'd0;
      mem_be_q    <= 2'b00;
      mem_wdata_q <= 16'd0;
      vid_data_q  <= 16'd0;
      cpu_rdata_q <= 16'd0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (to_fire) begin
          state_d = ST_DONE;
        end else if (!mem_busy) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT:  if (mem_ack || to_fire) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = (state_d == ST_ISSUE);
    vid_ack_d   = (state_d == ST_DONE) && (owner_q == OWN_VID);
    cpu_ack_d   = (state_d == ST_DONE) && (owner_q == OWN_CPU);

    if (grant) begin
      owner_d = grant_owner;
      if (grant_owner == OWN_CPU) begin
        mem_we_d    = cpu_we;
        mem_addr_d  = cpu_addr;
        mem_be_d    = cpu_be;
        mem_wdata_d = cpu_wdata;
      end else begin
        mem_we_d   = 1'b0;
        mem_addr_d = vid_word_addr(VID_BASE, vid_addr);
        mem_be_d   = 2'b11;
      end
    end

    if (ack_done) begin
      if (owner_q == OWN_VID) begin
        vid_data_d = mem_rdata;
      end else if (!mem_we_q) begin
        cpu_rdata_d = mem_rdata;
      end
    end else if (to_fire) begin
      if (owner_q == OWN_VID) begin
        vid_data_d = TIMEOUT_FILL;
      end else begin
        cpu_rdata_d = TIMEOUT_FILL;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign vid_data  = vid_data_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_ack   = cpu_ack_q;

endmodule

// File: tb/tb_bk_memarb.sv
// tb/tb_bk_memarb.sv - directed self-checking bench for bk_memarb
module tb_bk_memarb;

  logic        clk25 = 1'b0;
  logic        reset_in;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_wdata;
  logic        mem_busy;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  logic [15:0] vid_data, cpu_rdata, mem_wdata;
  logic        vid_ack, cpu_ack, mem_req, mem_we, arb_err;
  logic [17:0] mem_addr;
  logic [1:0]  mem_be;

  logic [15:0] w_vid_data, w_cpu_rdata, w_mem_wdata;
  logic        w_vid_ack, w_cpu_ack, w_mem_req, w_mem_we, w_arb_err;
  logic [17:0] w_mem_addr;
  logic [1:0]  w_mem_be;

  int errors = 0;
  int checks = 0;

  always #5 clk25 = ~clk25;

  bk_memarb #(.TIMEOUT(16)) u_dut (
    .clk25(clk25), .reset_in(reset_in),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  bk_memarb #(.VID_BASE(18'h3FFFF), .TIMEOUT(16)) u_wrap (
    .clk25(clk25), .reset_in(reset_in),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(w_vid_data), .vid_ack(w_vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(w_cpu_rdata), .cpu_ack(w_cpu_ack),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_be(w_mem_be),
    .mem_wdata(w_mem_wdata), .mem_busy(mem_busy), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .arb_err(w_arb_err)
  );

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    tick();
    tick();
    reset_in = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0h want 0", mem_we); end
    checks++; if (mem_addr !== 18'h0) begin errors++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    checks++; if (mem_be !== 2'b00) begin errors++; $display("FAIL reset_mem_be: got %0h want 0", mem_be); end
    checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
    checks++; if ({vid_data, cpu_rdata} !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h/%0h want 0/0", vid_data, cpu_rdata); end
    checks++; if ({vid_ack, cpu_ack, arb_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {vid_ack, cpu_ack, arb_err}); end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00100; cpu_be = 2'b11; cpu_wdata = 16'h0;
    mem_busy = 1'b0;
    tick(); // cycle 1
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rd_mem_req_c1: got %0h want 1", mem_req); end
    checks++; if (mem_addr !== 18'h00100) begin errors++; $display("FAIL rd_mem_addr: got %0h want 100", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we: got %0h want 0", mem_we); end
    tick(); // cycle 2
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_mem_req_c2: got %0h want 0", mem_req); end
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    tick(); // cycle 3
    mem_ack = 1'b0; cpu_req = 1'b0;
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_cpu_ack_c3: got %0h want 1", cpu_ack); end
    checks++; if (cpu_rdata !== 16'hA5A5) begin errors++; $display("FAIL rd_cpu_rdata: got %0h want a5a5", cpu_rdata); end
    checks++; if (vid_ack !== 1'b0) begin errors++; $display("FAIL rd_vid_ack: got %0h want 0", vid_ack); end
    tick();
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_width: got %0h want 0", cpu_ack); end
    checks++; if (cpu_rdata !== 16'hA5A5) begin errors++; $display("FAIL rd_rdata_held: got %0h want a5a5", cpu_rdata); end
  endtask

  task automatic test_cpu_write_stall();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h12345; cpu_be = 2'b01; cpu_wdata = 16'hBEEF;
    mem_busy = 1'b1;
    tick(); // cycle 1
    for (int j = 0; j < 5; j++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b1, 18'h12345, 2'b01, 16'hBEEF}) begin
        errors++;
        $display("FAIL wr_stall_fields[%0d]: got req=%0h we=%0h addr=%0h be=%0h wd=%0h want 1 1 12345 1 beef",
                 j, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
      end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_stall_ack[%0d]: got %0h want 0", j, cpu_ack); end
      tick();
    end
    mem_busy = 1'b0; // cycle 6
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL wr_mem_req_c6: got %0h want 1", mem_req); end
    tick(); // cycle 7
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wr_mem_req_c7: got %0h want 0", mem_req); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_early: got %0h want 0", cpu_ack); end
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick(); // cycle 8
    mem_ack = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_cpu_ack_c8: got %0h want 1", cpu_ack); end
    checks++; if (cpu_rdata !== 16'hA5A5) begin errors++; $display("FAIL wr_rdata_unchanged: got %0h want a5a5", cpu_rdata); end
    tick();
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_width: got %0h want 0", cpu_ack); end
  endtask

  task automatic test_video();
    logic [12:0] va [2];
    logic [17:0] ea [2];
    logic [17:0] wa [2];
    logic [15:0] vd [2];
    va[0] = 13'h1FFF; ea[0] = 18'h03FFF; wa[0] = 18'h01FFE; vd[0] = 16'h1234;
    va[1] = 13'h0002; ea[1] = 18'h02002; wa[1] = 18'h00001; vd[1] = 16'h4321;
    for (int k = 0; k < 2; k++) begin
      vid_req = 1'b1; vid_addr = va[k];
      tick(); // cycle 1
      checks++; if (mem_addr !== ea[k]) begin errors++; $display("FAIL vid_addr[%0d]: got %0h want %0h", k, mem_addr, ea[k]); end
      checks++; if (w_mem_addr !== wa[k]) begin errors++; $display("FAIL vid_addr_wrap[%0d]: got %0h want %0h", k, w_mem_addr, wa[k]); end
      checks++; if ({mem_req, mem_we, mem_be} !== 4'b1011) begin errors++; $display("FAIL vid_ctl[%0d]: got req/we/be=%b want 1011", k, {mem_req, mem_we, mem_be}); end
      tick(); // cycle 2
      mem_ack = 1'b1; mem_rdata = vd[k];
      tick(); // cycle 3
      mem_ack = 1'b0; vid_req = 1'b0;
      checks++; if ({vid_ack, cpu_ack} !== 2'b10) begin errors++; $display("FAIL vid_ack[%0d]: got vid/cpu=%b want 10", k, {vid_ack, cpu_ack}); end
      checks++; if (vid_data !== vd[k]) begin errors++; $display("FAIL vid_data[%0d]: got %0h want %0h", k, vid_data, vd[k]); end
      checks++; if (cpu_rdata !== 16'hA5A5) begin errors++; $display("FAIL vid_cpu_rdata[%0d]: got %0h want a5a5", k, cpu_rdata); end
      tick();
      checks++; if (vid_ack !== 1'b0) begin errors++; $display("FAIL vid_ack_width[%0d]: got %0h want 0", k, vid_ack); end
    end
  endtask

  task automatic test_fairness();
    logic [9:0]  exp_cpu;
    logic [17:0] exp_addr;
    exp_cpu = 10'b10_0001_0000; // grants V,V,V,V,C,V,V,V,V,C (bit i = grant i)
    vid_req = 1'b1; vid_addr = 13'h0010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00300; cpu_be = 2'b11;
    mem_busy = 1'b0; mem_rdata = 16'h0F0F;
    for (int i = 0; i < 10; i++) begin
      tick(); // ISSUE
      exp_addr = exp_cpu[i] ? 18'h00300 : 18'h02010;
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL fair_addr[%0d]: got %0h want %0h", i, mem_addr, exp_addr); end
      tick(); // WAIT
      mem_ack = 1'b1;
      tick(); // DONE
      mem_ack = 1'b0;
      checks++;
      if ({cpu_ack, vid_ack} !== {exp_cpu[i], ~exp_cpu[i]}) begin
        errors++;
        $display("FAIL fair_order[%0d]: got cpu/vid=%b want %b", i, {cpu_ack, vid_ack}, {exp_cpu[i], ~exp_cpu[i]});
      end
      if (i == 9) begin
        vid_req = 1'b0; cpu_req = 1'b0;
      end
      tick(); // IDLE
    end
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00400; mem_busy = 1'b0;
    tick(); // ISSUE
    tick(); // WAIT
    reset_in = 1'b1; cpu_req = 1'b0;
    tick();
    reset_in = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hBBBB;
    tick();
    mem_ack = 1'b0;
    checks++; if ({vid_ack, cpu_ack, mem_req, mem_we} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b want 0000", {vid_ack, cpu_ack, mem_req, mem_we}); end
    checks++; if (mem_addr !== 18'h0) begin errors++; $display("FAIL rstmid_addr: got %0h want 0", mem_addr); end
    checks++; if ({cpu_rdata, vid_data} !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %0h/%0h want 0/0", cpu_rdata, vid_data); end
    checks++; if ({mem_be, mem_wdata} !== 18'h0) begin errors++; $display("FAIL rstmid_be_wd: got %0h/%0h want 0/0", mem_be, mem_wdata); end
    tick();
    checks++; if ({vid_ack, cpu_ack, mem_req} !== 3'b000) begin errors++; $display("FAIL rstmid_later: got %b want 000", {vid_ack, cpu_ack, mem_req}); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00500; mem_busy = 1'b0;
    while (n < 40 && cpu_ack !== 1'b1) begin
      tick();
      n++;
    end
    cpu_req = 1'b0;
    checks++; if (n !== 18) begin errors++; $display("FAIL to_ack_cycle: got %0d want 18", n); end
    checks++; if (cpu_rdata !== 16'hFFFF) begin errors++; $display("FAIL to_fill: got %0h want ffff", cpu_rdata); end
    checks++; if ({arb_err, mem_req} !== 2'b10) begin errors++; $display("FAIL to_err_req: got %b want 10", {arb_err, mem_req}); end
    tick();
    cpu_req = 1'b1; cpu_addr = 18'h00600;
    tick(); // ISSUE
    tick(); // WAIT
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick(); // DONE
    mem_ack = 1'b0; cpu_req = 1'b0;
    checks++; if ({cpu_ack, arb_err} !== 2'b11) begin errors++; $display("FAIL to_next_ack_err: got %b want 11", {cpu_ack, arb_err}); end
    checks++; if (cpu_rdata !== 16'h1111) begin errors++; $display("FAIL to_next_data: got %0h want 1111", cpu_rdata); end
    tick();
  endtask
`else
  task automatic test_timeout();
    checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL no_to_arb_err: got %0h want 0", arb_err); end
  endtask
`endif

  initial begin
    reset_in = 1'b1; vid_req = 1'b0; vid_addr = 13'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 18'h0; cpu_be = 2'b00; cpu_wdata = 16'h0;
    mem_busy = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
    test_reset();
    test_cpu_read();
    test_cpu_write_stall();
    test_video();
    test_fairness();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
